// File: rtl/logits_topk_pkg.sv
// logits_topk_pkg
// Shared types for the logits top-K selector.
//   state_t      : controller states (S_IDLE, S_SCAN, S_OUT)
//   entry_bits() : width of one packed list entry {valid, idx, val}; the entry
//                  struct itself is declared inside each module because its
//                  field widths depend on module parameters.
package logits_topk_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    function automatic int entry_bits(input int idx_w, input int data_w);
        return 1 + idx_w + data_w;
    endfunction

endpackage

// File: rtl/logits_topk_if.sv
// logits_topk_if
// Bundles the frame input (pulse, no backpressure) and the result output
// (valid/ready) of logits_topk.
//   in_valid / logits_in : one-cycle frame strobe and flat logit vector
//   in_ready             : selector idle and able to take a frame
//   dropped              : one-cycle pulse, a frame arrived while busy
//   out_valid / out_ready: result handshake
//   topk_idx / topk_val  : ranked results, rank 0 in the low slice
// master = producer/consumer side, slave = logits_topk.
interface logits_topk_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CLASSES = 1000,
    parameter int K           = 5
);
    localparam int IDX_W = $clog2(NUM_CLASSES);

    logic                              in_valid;
    logic [DATA_WIDTH*NUM_CLASSES-1:0] logits_in;
    logic                              in_ready;
    logic                              dropped;
    logic                              out_valid;
    logic                              out_ready;
    logic [IDX_W*K-1:0]                topk_idx;
    logic [DATA_WIDTH*K-1:0]           topk_val;

    modport master (
        output in_valid, logits_in, out_ready,
        input  in_ready, dropped, out_valid, topk_idx, topk_val
    );

    modport slave (
        input  in_valid, logits_in, out_ready,
        output in_ready, dropped, out_valid, topk_idx, topk_val
    );

endinterface

// File: rtl/logits_topk_insert.sv
// topk_insert
// Combinational insertion of one candidate into a descending K-entry list.
//   i_list     : current list, entry r at [(r+1)*EW-1 -: EW], EW = 1+IDX_W+DATA_WIDTH
//   i_cand_idx : candidate class index
//   i_cand_val : candidate logit (signed)
//   o_list     : list after insertion (same packing)
// An incumbent with an equal value keeps its rank, so earlier classes win ties.
module topk_insert
    import logits_topk_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 10,
    parameter int K          = 5
) (
    input  logic [K*entry_bits(IDX_W, DATA_WIDTH)-1:0] i_list,
    input  logic [IDX_W-1:0]                           i_cand_idx,
    input  logic signed [DATA_WIDTH-1:0]               i_cand_val,
    output logic [K*entry_bits(IDX_W, DATA_WIDTH)-1:0] o_list
);

    typedef struct packed {
        logic                         valid;
        logic [IDX_W-1:0]             idx;
        logic signed [DATA_WIDTH-1:0] val;
    } entry_t;

    entry_t [K-1:0] w_in;
    entry_t [K-1:0] w_prev;
    entry_t [K-1:0] w_out;
    entry_t         w_cand;
    logic   [K-1:0] w_ge;
    int             w_pos;

    assign w_in   = i_list;
    assign o_list = w_out;

    always_comb begin
        w_cand.valid = 1'b1;
        w_cand.idx   = i_cand_idx;
        w_cand.val   = i_cand_val;
    end

    // The list is kept sorted with valid entries packed at the top, so the
    // entries that beat-or-tie the candidate form a prefix and their count is
    // the insert position.
    always_comb begin
        w_ge  = '0;
        w_pos = 0;
        for (int r = 0; r < K; r++) begin
            w_ge[r] = w_in[r].valid && ($signed(w_in[r].val) >= $signed(i_cand_val));
            if (w_ge[r]) w_pos = w_pos + 1;
        end
    end

    always_comb begin
        w_prev    = '0;
        for (int r = 1; r < K; r++) begin
            w_prev[r] = w_in[r-1];
        end
    end

    // Ranks above the position keep their entry, the position takes the
    // candidate, ranks below take the entry one rank up; the last one falls off.
    always_comb begin
        w_out = '0;
        for (int r = 0; r < K; r++) begin
            if (r < w_pos)       w_out[r] = w_in[r];
            else if (r == w_pos) w_out[r] = w_cand;
            else                 w_out[r] = w_prev[r];
        end
    end

endmodule

// File: rtl/logits_topk.sv
// logits_topk
// Reports the K highest logits of a frame (index and value, descending).
// A frame is captured whole, then scanned one class per clock through a
// single topk_insert instance; the result is held until the consumer takes it.
//   clk, rst_n : clock, asynchronous active-low reset
//   io_bus     : logits_topk_if.slave (frame input, dropped flag, result handshake)
//
// state  | meaning
// S_IDLE | waiting for a frame; in_ready = 1
// S_SCAN | inserting class cnt into the running list
// S_OUT  | result valid, waiting for out_ready
module logits_topk
    import logits_topk_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CLASSES = 1000,
    parameter int K           = 5
) (
    input logic           clk,
    input logic           rst_n,
    logits_topk_if.slave  io_bus
);

    localparam int IDX_W = $clog2(NUM_CLASSES);
    localparam int EW    = entry_bits(IDX_W, DATA_WIDTH);

    typedef struct packed {
        logic                         valid;
        logic [IDX_W-1:0]             idx;
        logic signed [DATA_WIDTH-1:0] val;
    } entry_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_in_ready;
    logic                    w_last;

    logic [DATA_WIDTH-1:0]   r_buf [NUM_CLASSES];
    logic [IDX_W-1:0]        r_cnt;
    entry_t [K-1:0]          r_list;
    entry_t [K-1:0]          w_list_next;
    logic [DATA_WIDTH-1:0]   w_cand_val;

    logic                    r_out_valid;
    logic                    r_dropped;
    logic [IDX_W*K-1:0]      r_topk_idx;
    logic [DATA_WIDTH*K-1:0] r_topk_val;

    assign w_last     = (r_cnt == IDX_W'(NUM_CLASSES - 1));
    assign w_cand_val = r_buf[r_cnt];

    topk_insert #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W),
        .K          (K)
    ) u_insert (
        .i_list     (r_list),
        .i_cand_idx (r_cnt),
        .i_cand_val (w_cand_val),
        .o_list     (w_list_next)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (io_bus.in_valid) w_state_next = S_SCAN;
            S_SCAN:  if (w_last) w_state_next = S_OUT;
            S_OUT:   if (r_out_valid && io_bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs decoded from state
    always_comb begin
        w_in_ready = (r_state == S_IDLE);
    end

    // Datapath: capture buffer, scan counter, running list, result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CLASSES; c++) r_buf[c] <= '0;
            r_cnt       <= '0;
            r_list      <= '0;
            r_out_valid <= 1'b0;
            r_dropped   <= 1'b0;
            r_topk_idx  <= '0;
            r_topk_val  <= '0;
        end else begin
            // Anything arriving outside S_IDLE, including during the output
            // handshake cycle, is lost and flagged.
            r_dropped <= io_bus.in_valid && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (io_bus.in_valid) begin
                        for (int c = 0; c < NUM_CLASSES; c++) begin
                            r_buf[c] <= io_bus.logits_in[c*DATA_WIDTH +: DATA_WIDTH];
                        end
                        r_list <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_SCAN: begin
                    r_list <= w_list_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Load from the post-insert list so the last class counts.
                        for (int r = 0; r < K; r++) begin
                            r_topk_idx[r*IDX_W +: IDX_W]           <= w_list_next[r].idx;
                            r_topk_val[r*DATA_WIDTH +: DATA_WIDTH] <= w_list_next[r].val;
                        end
                        r_out_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (io_bus.out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.dropped   = r_dropped;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.topk_idx  = r_topk_idx;
    assign io_bus.topk_val  = r_topk_val;

endmodule
